reg_addr_demux: RTL

Registered 1-to-2 demultiplexer for 5-bit register-address tokens, the steering counterpart of the datapath's 2:1 register-address mux. One input stream is routed by a per-token select bit to one of two output channels, each buffered by a one-entry holding slot. It sits between decode and the two consumers of a destination-register address, write-back tag and hazard scoreboard, and applies valid/ready flow control on every channel.

---
 rtl/mini_cpu_pkg.sv | 18 +
 rtl/reg_addr_slot.sv | 64 ++++++
 rtl/reg_addr_demux.sv | 82 ++++++++
 3 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU datapath: register-address width,
// holding-slot state encoding and the delivered-token counter width.
package mini_cpu_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STATS_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reg_addr_slot.sv
// One-entry valid/ready holding register. A load while FULL is only issued
// by the parent when the slot is draining in the same cycle, so the new
// token replaces the departing one and valid stays high.
module reg_addr_slot
    import mini_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = REG_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drain
);

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [WIDTH-1:0] data_q;

    // Slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and drain decode.
    always_comb begin
        state_d = state_q;
        drain   = 1'b0;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                drain = out_ready;
                if (out_ready && !load) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Token storage; holds the last value while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/reg_addr_demux.sv
// Registered 1-to-2 demultiplexer for register-address tokens. in_sel steers
// each accepted token into one of two one-entry holding slots.
// Optional feature: define REG_ADDR_DEMUX_STATS_EN to add saturating
// per-channel delivered-token counters (out0_count, out1_count).
module reg_addr_demux
    import mini_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic                   out1_valid,
    input  logic                   out1_ready
`ifdef REG_ADDR_DEMUX_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0] out0_count,
    output logic [STATS_CNT_W-1:0] out1_count
`endif
);

    logic accept;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;
    logic room0;
    logic room1;

    // Selected slot has room if empty or emptying this cycle; in_valid not involved.
    always_comb begin
        room0    = !out0_valid || out0_ready;
        room1    = !out1_valid || out1_ready;
        in_ready = in_sel ? room1 : room0;
        accept   = in_valid && in_ready;
        load0    = accept && !in_sel;
        load1    = accept && in_sel;
    end

    reg_addr_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load0),
        .load_data (in_data),
        .out_ready (out0_ready),
        .out_valid (out0_valid),
        .out_data  (out0_data),
        .drain     (drain0)
    );

    reg_addr_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1),
        .load_data (in_data),
        .out_ready (out1_ready),
        .out_valid (out1_valid),
        .out_data  (out1_data),
        .drain     (drain1)
    );

`ifdef REG_ADDR_DEMUX_STATS_EN
    // Saturating count of tokens delivered on each channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            out0_count <= '0;
            out1_count <= '0;
        end else begin
            if (drain0) out0_count <= sat_inc(out0_count);
            if (drain1) out1_count <= sat_inc(out1_count);
        end
    end
`endif

endmodule
